// File: rtl/bringup_uart_rx.sv
// rtl/bringup_uart_rx.sv - 8N1 UART receiver with one-entry valid/ready output register
//
// Purpose:
//   Receives 8N1 serial bytes, LSB first, from the bringup board FTDI pad.
//   The line is oversampled by the system clock. Received bytes are presented
//   on a one-entry valid/ready output register. Framing errors and overruns
//   are reported as single-cycle pulses.
//
// Build option:
//   BRINGUP_UART_RX_MAJORITY_EN - when defined, every start, data and stop
//   decision is the 2-of-3 majority of rx_s taken at counter==2, 1 and 0.
//   When undefined, the decision is the single sample at counter==0.
//   Decision timing is the same in both builds.
//
// Parameters:
//   CLOCKS_PER_BAUD - system clocks per bit time (must be >= 8)
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   rx_i           in   raw serial line, idle high, asynchronous to clock
//   data_o[7:0]    out  received byte, stable while valid_o is high
//   valid_o        out  data_o holds an unconsumed byte
//   ready_i        in   consumer takes data_o when valid_o && ready_i
//   busy_o         out  receiver FSM is not idle
//   frame_error_o  out  one-cycle pulse, stop bit sampled low
//   overrun_o      out  one-cycle pulse, completed byte dropped (output full)

module bringup_uart_rx #(
  parameter int CLOCKS_PER_BAUD = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       frame_error_o,
  output logic       overrun_o
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam int HALF  = CLOCKS_PER_BAUD / 2;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BAUD_M1 = CNT_W'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;

  logic sync1_q;
  logic rx_s;
  logic tick;
  logic bit_val;
  logic byte_done;
  logic frame_err;

  // Two-flop synchroniser; both stages reset to the idle (high) level so a
  // reset release never looks like a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s    <= sync1_q;
    end
  end

  assign tick = (state_q != S_IDLE) && (cnt_q == '0);

`ifdef BRINGUP_UART_RX_MAJORITY_EN
  // Capture the two samples ahead of the decision point; the third is the
  // live rx_s at counter==0, so the decision lands on the same cycle as the
  // single-sample build.
  logic maj2_q;
  logic maj1_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      maj2_q <= 1'b1;
      maj1_q <= 1'b1;
    end else begin
      if (cnt_q == CNT_W'(2)) maj2_q <= rx_s;
      if (cnt_q == CNT_W'(1)) maj1_q <= rx_s;
    end
  end

  assign bit_val = (maj2_q & maj1_q) | (maj2_q & rx_s) | (maj1_q & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // FSM state register and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic. The counter free-runs down to zero; each tick reloads
  // it so successive decisions stay one bit time apart from the mid-start
  // sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end

      S_START: begin
        if (tick) begin
          if (bit_val) begin
            // Line went back high before mid-start: treat as noise.
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            cnt_d   = BAUD_M1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d[idx_q] = bit_val;
          cnt_d          = BAUD_M1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (bit_val) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        // A held-low line (break) parks here so it cannot re-trigger START
        // or raise further error pulses.
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

  // One-entry output register. A byte completing while the consumer is
  // taking the current one replaces it directly, so a one-cycle-late ready
  // never costs a byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_o        <= '0;
      valid_o       <= 1'b0;
      frame_error_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      frame_error_o <= frame_err;
      overrun_o     <= byte_done && valid_o && !ready_i;
      if (byte_done) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift_q;
          valid_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bringup_uart_rx.sv
// tb/tb_bringup_uart_rx.sv - self-checking bench for bringup_uart_rx

module tb_bringup_uart_rx;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic       frame_error_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cyc = 0;

  bringup_uart_rx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_i          (rx_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .busy_o        (busy_o),
    .frame_error_o (frame_error_o),
    .overrun_o     (overrun_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observer: sampled just after the falling edge, once the stimulus for the
  // coming rising edge has settled.
  always begin
    @(negedge clock);
    #1;
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (frame_error_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (valid_o) valid_cyc++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      repeat (CPB) @(negedge clock);
    end
    rx_i = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (frame_error_o !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", frame_error_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", overrun_o); end
  endtask

  task automatic test_single();
    int n;
    int fe0, ov0, vc0, exp_lat;
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cyc;
    // 2 synchroniser stages, half a bit to mid-start, 9 more bit times to the
    // stop sample, and the output register edge.
    exp_lat = 2 + CPB / 2 + 9 * CPB + 1;
    n = 0;
    fork
      send_byte(8'h41, 1'b1);
      begin
        while (!valid_o && n < 400) begin
          @(posedge clock);
          n++;
          @(negedge clock);
        end
      end
    join
    repeat (4) @(negedge clock);
    checks++;
    if (n >= 400) begin errors++; $display("FAIL single_latency: timeout after %0d cycles, expected %0d", n, exp_lat); end
    else if (n != exp_lat) begin errors++; $display("FAIL single_latency: got %0d expected %0d", n, exp_lat); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h41) begin errors++; $display("FAIL single_data: got %0d bytes first %h expected 1 byte 41", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (valid_cyc - vc0 != 1) begin errors++; $display("FAIL single_valid_width: got %0d expected 1", valid_cyc - vc0); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL single_fe: got %0d expected 0", fe_cnt - fe0); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL single_ov: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_false_start();
    got_q.delete();
    rx_i = 1'b0;
    repeat (3) @(negedge clock);
    rx_i = 1'b1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL false_start_busy_rise: got %b expected 1", busy_o); end
    repeat (9) @(negedge clock);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL false_start_busy_fall: got %b expected 0", busy_o); end
    repeat (CPB * 2) @(negedge clock);
    checks++; if (got_q.size() != 0 || valid_o !== 1'b0) begin errors++; $display("FAIL false_start_no_byte: got %0d bytes valid %b expected 0 bytes valid 0", got_q.size(), valid_o); end
  endtask

  task automatic test_frame_error();
    int fe0, ov0;
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h55, 1'b0);
    rx_i = 1'b0;
    repeat (100) @(negedge clock);
    rx_i = 1'b1;
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL frame_error_pulses: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (got_q.size() != 0 || valid_o !== 1'b0) begin errors++; $display("FAIL frame_error_no_byte: got %0d bytes expected 0", got_q.size()); end
    repeat (2 * CPB) @(negedge clock);
    send_byte(8'h5A, 1'b1);
    repeat (CPB) @(negedge clock);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin errors++; $display("FAIL frame_error_recover: got %0d bytes first %h expected 1 byte 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (ov_cnt != ov0 || fe_cnt - fe0 != 1) begin errors++; $display("FAIL frame_error_other_pulses: ov %0d fe %0d expected ov 0 fe 1", ov_cnt - ov0, fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    int fe0, ov0;
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    ready_i = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (4) @(negedge clock);
    checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL overrun_data_held: got %h expected 11", data_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL overrun_valid_held: got %b expected 1", valid_o); end
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL overrun_pulses: got %0d expected 1", ov_cnt - ov0); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL overrun_fe: got %0d expected 0", fe_cnt - fe0); end
    ready_i = 1'b1;
    @(negedge clock);
    ready_i = 1'b0;
    @(negedge clock);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL overrun_drain: got valid %b expected 0", valid_o); end
    ready_i = 1'b1;
    send_byte(8'h33, 1'b1);
    repeat (CPB) @(negedge clock);
    checks++; if (got_q.size() != 2 || got_q[0] !== 8'h11 || got_q[1] !== 8'h33) begin errors++; $display("FAIL overrun_sequence: got %0d bytes expected 11 then 33", got_q.size()); end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    int fe0, ov0;
    got_q.delete();
    b = 8'h7E;
    rx_i = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx_i = b[4];
    repeat (CPB / 2) @(negedge clock);
    fe0 = fe_cnt; ov0 = ov_cnt;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (data_o !== 8'h00 || valid_o !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got data %h valid %b expected 00 0", data_o, valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy_o); end
    rx_i = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    send_byte(8'hA5, 1'b1);
    repeat (CPB) @(negedge clock);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin errors++; $display("FAIL midreset_next_byte: got %0d bytes first %h expected 1 byte a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL midreset_pulses: fe %0d ov %0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  task automatic test_glitch();
    logic [7:0] exp_b;
    int fe0;
`ifdef BRINGUP_UART_RX_MAJORITY_EN
    exp_b = 8'h00;
`else
    exp_b = 8'h01;
`endif
    got_q.delete();
    fe0 = fe_cnt;
    rx_i = 1'b0;
    repeat (CPB + CPB / 2) @(negedge clock);
    rx_i = 1'b1;
    @(negedge clock);
    rx_i = 1'b0;
    repeat (CPB / 2 - 1 + 7 * CPB) @(negedge clock);
    rx_i = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_b) begin errors++; $display("FAIL glitch_data: got %0d bytes first %h expected 1 byte %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_b); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_fe: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    got_q.delete();
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b1);
      repeat ($urandom_range(0, 12)) @(negedge clock);
    end
    repeat (CPB) @(negedge clock);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    repeat (4) @(negedge clock);
    test_single();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_reset_mid_byte();
    test_glitch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bringup_uart_rx.md
Name: bringup_uart_rx

Overview:
- UART receiver for the bringup board: 8N1, LSB first, oversampled by the system clock.
- Takes the raw uart_rx pad (FTDI side) and presents received bytes on a one-entry valid/ready output register.
- Sits on the receive side of the bringup UART path and feeds a command/echo stage, which may loop bytes back to the transmitter.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
CLOCKS_PER_BAUD, 104, system clocks per bit; 104 gives 115200 baud at 12 MHz; must be >= 8.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
rx_i  input  1  raw serial line, idle high; asynchronous to clock
data_o  output  8  received byte; stable while valid_o is high
valid_o  output  1  data_o holds an unconsumed byte
ready_i  input  1  consumer accepts data_o in a cycle where valid_o && ready_i
busy_o  output  1  high whenever the FSM is not in IDLE
frame_error_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: completed byte dropped because the output register was full

Behaviour:
- Reset values:
  - data_o=0, valid_o=0, busy_o=0, frame_error_o=0, overrun_o=0.
  - FSM=IDLE, counter=0, both synchroniser flops=1.
- Input synchroniser:
  - rx_i passes through two flops to give rx_s.
  - All decisions use rx_s only, adding 2 cycles of latency.
- Counter:
  - Down-counter, width $clog2(CLOCKS_PER_BAUD).
  - HALF = CLOCKS_PER_BAUD/2 (integer division).
  - "Tick" means counter==0 in a non-IDLE state.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START, counter=HALF-1.
  - START at tick:
    - sample 1 (false start) -> IDLE, no output;
    - sample 0 -> DATA, bit index=0, counter=CLOCKS_PER_BAUD-1.
  - DATA: at each tick, shift the sample into bit [index] and reload the counter. After index 7 -> STOP.
  - STOP at tick:
    - sample 1 -> byte complete, go to IDLE;
    - sample 0 -> frame_error_o pulse for 1 cycle, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then -> IDLE. A held-low line or break never produces bytes or repeated error pulses.
- Output register:
  - On byte complete with valid_o==0, or with valid_o&&ready_i in the same cycle: data_o updates and valid_o=1 on the next edge.
  - On byte complete with valid_o==1 and ready_i==0: byte dropped, overrun_o pulses for 1 cycle, data_o/valid_o unchanged.
  - valid_o&&ready_i with no new byte: valid_o=0 next edge; data_o keeps its old value.
- Timing: from the rx_s falling edge, the stop-bit sample occurs HALF + 9*CLOCKS_PER_BAUD cycles later; valid_o rises 1 cycle after that.
- Reset asserted mid-byte: everything returns to reset values immediately; the partial byte is lost, with no error pulse.
- frame_error_o and overrun_o are mutually exclusive per byte.

Optional Feature:
- Macro: BRINGUP_UART_RX_MAJORITY_EN
- Defined:
  - Each start, data and stop decision is the 2-of-3 majority of rx_s at counter==2, 1 and 0; the decision is made at counter==0.
  - A single-cycle glitch near mid-bit is rejected.
- Undefined: the decision is the single rx_s sample at counter==0. Timing is identical in both builds.

Test Plan:
- CLOCKS_PER_BAUD=16; send 0x41 with a valid stop bit, ready_i=1.
  -> valid_o for exactly 1 cycle with data_o=0x41, 8+144+1 cycles after the rx_s fall; no error pulses.
- rx_i low for 3 cycles, then high.
  -> false start; returns to IDLE, busy_o drops by cycle ~11, valid_o stays 0.
- Send 0x55 with stop bit low, then hold rx_i low for 100 cycles.
  -> frame_error_o exactly 1 pulse, valid_o stays 0; after rx_i returns high, 0x5A is received correctly.
- ready_i=0; send 0x11 then 0x22.
  -> data_o=0x11 held, overrun_o 1 pulse at the second stop sample.
  -> After ready_i=1 for one cycle, valid_o=0; next byte 0x33 is received normally.
- Assert reset during bit 4 of 0x7E, release, then send 0xA5.
  -> all outputs 0 during reset; only 0xA5 is delivered.
- With the macro defined: 1-cycle high glitch at the mid-bit of data bit 0 of 0x00 -> data_o=0x00.
- Without the macro, the same stimulus -> data_o=0x01.
